// File: rtl/axil_ram_slv.sv
`timescale 1ns/1ps
// AXI4-Lite responder in front of a word-addressed RAM with byte strobes.
// Writes accept AW and W together and answer with one B beat.
// Reads allow one AR at a time and return R one cycle after the AR handshake.
// Any address outside [BASE_ADDR, BASE_ADDR + DEPTH*4) completes with SLVERR
// and leaves memory untouched.
module axil_ram_slv #(
   parameter int unsigned       ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h2000_0000,
   parameter int unsigned       DEPTH     = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] s_axi_awaddr,
   input  logic [2:0]        s_axi_awprot,
   input  logic              s_axi_awvalid,
   output logic              s_axi_awready,
   input  logic [31:0]       s_axi_wdata,
   input  logic [3:0]        s_axi_wstrb,
   input  logic              s_axi_wvalid,
   output logic              s_axi_wready,
   output logic [1:0]        s_axi_bresp,
   output logic              s_axi_bvalid,
   input  logic              s_axi_bready,
   input  logic [ADDR_W-1:0] s_axi_araddr,
   input  logic [2:0]        s_axi_arprot,
   input  logic              s_axi_arvalid,
   output logic              s_axi_arready,
   output logic [31:0]       s_axi_rdata,
   output logic [1:0]        s_axi_rresp,
   output logic              s_axi_rvalid,
   input  logic              s_axi_rready
);

   localparam int unsigned IDX_W  = $clog2(DEPTH);
   localparam logic [1:0]  OKAY   = 2'b00;
   localparam logic [1:0]  SLVERR = 2'b10;

   typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
   typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

   // An offset lies in the window when every bit above the word index is zero
   // (DEPTH is a power of two, so this equals off < DEPTH*4).
   function automatic logic in_window(input logic [ADDR_W-1:0] off);
      return ((off >> (IDX_W + 2)) == '0);
   endfunction

   logic [31:0]       mem_r [0:DEPTH-1];

   w_state_t          w_state_r;
   w_state_t          w_state_nxt_s;
   r_state_t          r_state_r;
   r_state_t          r_state_nxt_s;

   logic [ADDR_W-1:0] wr_off_s;
   logic [ADDR_W-1:0] rd_off_s;
   logic              wr_in_rng_s;
   logic              rd_in_rng_s;
   logic [IDX_W-1:0]  wr_idx_s;
   logic [IDX_W-1:0]  rd_idx_s;

   logic              b_busy_s;
   logic              wr_acc_s;
   logic              rd_acc_s;
   logic              rvalid_s;

   logic [1:0]        bresp_r;
   logic [1:0]        rresp_r;
   logic [31:0]       rdata_r;

   // Protection attributes carry no meaning for this memory.
   logic              unused_prot_s;
   assign unused_prot_s = ^{s_axi_awprot, s_axi_arprot};

   // Address decode for both channels; subtraction wraps modulo 2^ADDR_W.
   always_comb begin
      wr_off_s    = s_axi_awaddr - BASE_ADDR;
      rd_off_s    = s_axi_araddr - BASE_ADDR;
      wr_in_rng_s = in_window(wr_off_s);
      rd_in_rng_s = in_window(rd_off_s);
      wr_idx_s    = wr_off_s[IDX_W+1:2];
      rd_idx_s    = rd_off_s[IDX_W+1:2];
   end

   // ---------------------------------------------------------------- write

   // Write FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         w_state_r <= W_IDLE;
      end else begin
         w_state_r <= w_state_nxt_s;
      end
   end

   // Write FSM next state: go busy on accept, return to idle on B handshake.
   always_comb begin
      w_state_nxt_s = w_state_r;
      case (w_state_r)
         W_IDLE: begin
            if (wr_acc_s) begin
               w_state_nxt_s = W_RESP;
            end else begin
               w_state_nxt_s = W_IDLE;
            end
         end
         W_RESP: begin
            if (s_axi_bready) begin
               w_state_nxt_s = W_IDLE;
            end else begin
               w_state_nxt_s = W_RESP;
            end
         end
         default: w_state_nxt_s = W_IDLE;
      endcase
   end

   // Write FSM outputs: AW and W are only taken together, never during reset.
   always_comb begin
      b_busy_s = (w_state_r == W_RESP);
      wr_acc_s = s_axi_awvalid & s_axi_wvalid & ~b_busy_s & ~rst;
   end

   // B response code captured on the accept edge and held until bready.
   always_ff @(posedge clk) begin
      if (rst) begin
         bresp_r <= OKAY;
      end else if (wr_acc_s) begin
         bresp_r <= wr_in_rng_s ? OKAY : SLVERR;
      end else begin
         bresp_r <= bresp_r;
      end
   end

   // RAM write port with per-byte enables; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_acc_s && wr_in_rng_s) begin
         for (int i = 0; i < 4; i++) begin
            if (s_axi_wstrb[i]) begin
               mem_r[wr_idx_s][8*i +: 8] <= s_axi_wdata[8*i +: 8];
            end
         end
      end
   end

   assign s_axi_awready = wr_acc_s;
   assign s_axi_wready  = wr_acc_s;
   assign s_axi_bvalid  = b_busy_s;
   assign s_axi_bresp   = bresp_r;

   // ----------------------------------------------------------------- read

   // Read FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state_r <= R_IDLE;
      end else begin
         r_state_r <= r_state_nxt_s;
      end
   end

   // Read FSM next state: hold data until the R handshake completes.
   always_comb begin
      r_state_nxt_s = r_state_r;
      case (r_state_r)
         R_IDLE: begin
            if (rd_acc_s) begin
               r_state_nxt_s = R_DATA;
            end else begin
               r_state_nxt_s = R_IDLE;
            end
         end
         R_DATA: begin
            if (s_axi_rready) begin
               r_state_nxt_s = R_IDLE;
            end else begin
               r_state_nxt_s = R_DATA;
            end
         end
         default: r_state_nxt_s = R_IDLE;
      endcase
   end

   // Read FSM outputs: arready follows the registered rvalid only.
   always_comb begin
      rvalid_s = (r_state_r == R_DATA);
      rd_acc_s = s_axi_arvalid & ~rvalid_s;
   end

   // Synchronous read port; a same-edge write is not yet visible here.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_r <= 32'h0000_0000;
         rresp_r <= OKAY;
      end else if (rd_acc_s) begin
         rdata_r <= rd_in_rng_s ? mem_r[rd_idx_s] : 32'h0000_0000;
         rresp_r <= rd_in_rng_s ? OKAY : SLVERR;
      end else begin
         rdata_r <= rdata_r;
         rresp_r <= rresp_r;
      end
   end

   assign s_axi_arready = ~rvalid_s;
   assign s_axi_rvalid  = rvalid_s;
   assign s_axi_rdata   = rdata_r;
   assign s_axi_rresp   = rresp_r;

endmodule

// File: tb/tb_axil_ram_slv.sv
`timescale 1ns/1ps
// Bench for axil_ram_slv: a table of write/readback vectors, hand-written
// handshake corner sequences, then random traffic against a word-map model.
module tb_axil_ram_slv;

   localparam int          ADDR_W = 32;
   localparam logic [31:0] BASE   = 32'h2000_0000;
   localparam int          DEPTH  = 1024;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [2:0]  awprot, arprot;
   logic [3:0]  wstrb;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [1:0]  bresp, rresp;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] mdl [int];

   axil_ram_slv #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid),
      .s_axi_awready(awready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
      .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_bresp(bresp),
      .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_araddr(araddr),
      .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid),
      .s_axi_rready(rready)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, got, exp);
      end
   endtask

   // ---- reference model: byte-addressed window onto a map of 32-bit words
   function automatic bit mdl_in(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return off < 32'(DEPTH * 4);
   endfunction

   task automatic mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] w;
      int          i;
      if (mdl_in(a)) begin
         i = int'((a - BASE) / 32'd4);
         w = mdl.exists(i) ? mdl[i] : 32'h0;
         for (int b = 0; b < 4; b++) begin
            if (s[b]) w[8*b +: 8] = d[8*b +: 8];
         end
         mdl[i] = w;
      end
   endtask

   function automatic logic [31:0] mdl_rdata(input logic [31:0] a);
      if (!mdl_in(a)) return 32'h0;
      return mdl[int'((a - BASE) / 32'd4)];
   endfunction

   function automatic logic [1:0] mdl_resp(input logic [31:0] a);
      return mdl_in(a) ? 2'b00 : 2'b10;
   endfunction

   // ---- bus tasks (drive at negedge, sample 1 ns later or 1 ns after posedge)
   task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output int waited);
      int n;
      @(negedge clk);
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      #1;
      n = 0;
      while (awready !== 1'b1 && n < 20) begin
         @(negedge clk); #1; n++;
      end
      waited = n;
      if (awready !== 1'b1) begin
         n_vec++; n_err++;
         $display("FAIL write_accept_timeout: awready=%b after %0d cycles, expected 1", awready, n);
         awvalid = 1'b0; wvalid = 1'b0; resp = 2'bxx;
         return;
      end
      chk("wready_with_awready", {31'h0, wready}, 32'h1);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      chk("bvalid_next_cycle", {31'h0, bvalid}, 32'h1);
      resp = bresp;
      mdl_write(a, d, s);
      @(posedge clk); #1;
      chk("bvalid_cleared", {31'h0, bvalid}, 32'h0);
   endtask

   task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
      int n;
      @(negedge clk);
      araddr = a; arvalid = 1'b1; rready = 1'b1;
      #1;
      n = 0;
      while (arready !== 1'b1 && n < 20) begin
         @(negedge clk); #1; n++;
      end
      if (arready !== 1'b1) begin
         n_vec++; n_err++;
         $display("FAIL read_accept_timeout: arready=%b, expected 1", arready);
         arvalid = 1'b0; d = 32'hx; resp = 2'bxx;
         return;
      end
      @(posedge clk); #1;
      arvalid = 1'b0;
      chk("rvalid_next_cycle", {31'h0, rvalid}, 32'h1);
      d = rdata; resp = rresp;
      @(posedge clk); #1;
      chk("rvalid_cleared", {31'h0, rvalid}, 32'h0);
   endtask

   typedef struct {
      logic [31:0] off;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp_rd;
      logic [1:0]  exp_b;
      logic [1:0]  exp_r;
   } vec_t;

   vec_t tbl [9];

   initial begin
      logic [31:0] rd;
      logic [1:0]  rs, bs;
      int          wt, bad, seen;
      logic [31:0] got;
      logic [31:0] a;
      int          pool [16];

      tbl[0] = '{32'h0000_0010, 32'h1234_5678, 4'b1111, 32'h1234_5678, 2'b00, 2'b00};
      tbl[1] = '{32'h0000_0010, 32'hAABB_CCDD, 4'b0101, 32'h12BB_56DD, 2'b00, 2'b00};
      tbl[2] = '{32'h0000_0010, 32'h0000_0000, 4'b0000, 32'h12BB_56DD, 2'b00, 2'b00};
      tbl[3] = '{32'h0000_0020, 32'h1122_3344, 4'b1111, 32'h1122_3344, 2'b00, 2'b00};
      tbl[4] = '{32'h0000_0023, 32'h0000_EE00, 4'b0010, 32'h1122_EE44, 2'b00, 2'b00};
      tbl[5] = '{32'h0000_0FFC, 32'hCAFE_BABE, 4'b1111, 32'hCAFE_BABE, 2'b00, 2'b00};
      tbl[6] = '{32'h0000_0000, 32'h0102_0304, 4'b1111, 32'h0102_0304, 2'b00, 2'b00};
      tbl[7] = '{32'h0000_1000, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000, 2'b10, 2'b10};
      tbl[8] = '{32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000, 2'b10, 2'b10};

      // Reset with a full write offered: it must not be accepted.
      rst = 1'b1; awprot = 3'b000; arprot = 3'b000;
      awaddr = BASE; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      bready = 1'b1; araddr = BASE; arvalid = 1'b0; rready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      chk("rst_awready", {31'h0, awready}, 32'h0);
      chk("rst_arready", {31'h0, arready}, 32'h1);
      chk("rst_bvalid", {31'h0, bvalid}, 32'h0);
      chk("rst_rvalid", {31'h0, rvalid}, 32'h0);
      chk("rst_resps", {28'h0, bresp, rresp}, 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      awvalid = 1'b0; wvalid = 1'b0;
      @(negedge clk); rst = 1'b0;

      // Table: write then read back each entry.
      for (int k = 0; k < 9; k++) begin
         axi_write(BASE + tbl[k].off, tbl[k].data, tbl[k].strb, bs, wt);
         chk($sformatf("tbl%0d_aw_same_cycle", k), wt, 32'd0);
         chk($sformatf("tbl%0d_bresp", k), {30'h0, bs}, {30'h0, tbl[k].exp_b});
         axi_read(BASE + tbl[k].off, rd, rs);
         chk($sformatf("tbl%0d_rdata", k), rd, tbl[k].exp_rd);
         chk($sformatf("tbl%0d_rresp", k), {30'h0, rs}, {30'h0, tbl[k].exp_r});
      end
      axi_read(BASE, rd, rs);
      chk("word0_intact", rd, 32'h0102_0304);
      axi_read(BASE + 32'h0FFC, rd, rs);
      chk("last_word_intact", rd, 32'hCAFE_BABE);

      // AW without W for 5 cycles while a read runs.
      @(negedge clk);
      awaddr = BASE + 32'h10; wdata = 32'hFFFF_FFFF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b0;
      araddr = BASE + 32'h10; arvalid = 1'b1; rready = 1'b1; bready = 1'b1;
      bad = 0; seen = 0; got = 32'h0;
      for (int c = 0; c < 5; c++) begin
         #1;
         if (awready !== 1'b0 || wready !== 1'b0 || bvalid !== 1'b0) bad++;
         if (rvalid === 1'b1 && seen == 0) begin got = rdata; seen = 1; end
         @(negedge clk);
         if (c == 0) arvalid = 1'b0;
      end
      awvalid = 1'b0;
      chk("aw_only_not_accepted", bad, 32'd0);
      chk("aw_only_read_seen", seen, 32'd1);
      chk("aw_only_read_data", got, 32'h12BB_56DD);
      axi_read(BASE + 32'h10, rd, rs);
      chk("aw_only_mem_unchanged", rd, 32'h12BB_56DD);

      // bready held low for 3 cycles with a second write waiting.
      @(negedge clk);
      awaddr = BASE + 32'h2C; wdata = 32'h0BAD_F00D; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
      #1;
      chk("hold_first_accept", {31'h0, awready}, 32'h1);
      @(posedge clk);
      mdl_write(BASE + 32'h2C, 32'h0BAD_F00D, 4'hF);
      @(negedge clk);
      awaddr = BASE + 32'h30; wdata = 32'h55AA_55AA;
      bad = 0;
      for (int c = 0; c < 3; c++) begin
         #1;
         if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) bad++;
         @(negedge clk);
      end
      chk("hold_b_stable_no_accept", bad, 32'd0);
      bready = 1'b1;
      #1;
      chk("hold_bready_cycle_awready", {31'h0, awready}, 32'h0);
      @(negedge clk); #1;
      chk("hold_after_b_bvalid", {31'h0, bvalid}, 32'h0);
      chk("hold_second_accept", {31'h0, awready}, 32'h1);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      mdl_write(BASE + 32'h30, 32'h55AA_55AA, 4'hF);
      chk("hold_second_bvalid", {31'h0, bvalid}, 32'h1);
      @(posedge clk); #1;
      axi_read(BASE + 32'h2C, rd, rs);
      chk("hold_first_data", rd, 32'h0BAD_F00D);
      axi_read(BASE + 32'h30, rd, rs);
      chk("hold_second_data", rd, 32'h55AA_55AA);

      // Same-cycle write and read of one word: read sees the old value.
      axi_write(BASE + 32'h40, 32'h7777_7777, 4'hF, bs, wt);
      @(negedge clk);
      awaddr = BASE + 32'h40; wdata = 32'h9999_9999; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      araddr = BASE + 32'h40; arvalid = 1'b1; rready = 1'b1; bready = 1'b1;
      #1;
      chk("rbw_both_ready", {30'h0, awready, arready}, 32'h3);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      mdl_write(BASE + 32'h40, 32'h9999_9999, 4'hF);
      chk("rbw_old_data", rdata, 32'h7777_7777);
      chk("rbw_both_valid", {30'h0, bvalid, rvalid}, 32'h3);
      @(posedge clk); #1;
      axi_read(BASE + 32'h40, rd, rs);
      chk("rbw_write_landed", rd, 32'h9999_9999);

      // Write offered on the edge reset is sampled must not commit.
      @(negedge clk);
      rst = 1'b1; awaddr = BASE + 32'h40; wdata = 32'h0000_DEAD; awvalid = 1'b1; wvalid = 1'b1;
      #1;
      chk("rst_write_awready", {31'h0, awready}, 32'h0);
      @(negedge clk);
      rst = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
      #1;
      chk("rst_write_no_b", {31'h0, bvalid}, 32'h0);
      axi_read(BASE + 32'h40, rd, rs);
      chk("rst_write_not_committed", rd, 32'h9999_9999);

      // Reset while rvalid is pending drops the R beat.
      @(negedge clk);
      araddr = BASE + 32'h10; arvalid = 1'b1; rready = 1'b0;
      @(posedge clk); #1;
      arvalid = 1'b0;
      chk("rst_mid_rvalid_up", {31'h0, rvalid}, 32'h1);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0; rready = 1'b1;
      #1;
      chk("rst_mid_rvalid_dropped", {31'h0, rvalid}, 32'h0);
      chk("rst_mid_arready", {31'h0, arready}, 32'h1);
      axi_read(BASE + 32'h10, rd, rs);
      chk("rst_mid_data_kept", rd, mdl_rdata(BASE + 32'h10));

      // Random traffic over a pool of initialised words plus out-of-range hits.
      for (int p = 0; p < 16; p++) begin
         pool[p] = (p < 8) ? p : DEPTH - 16 + p;
         axi_write(BASE + 32'(pool[p] * 4), $urandom, 4'hF, bs, wt);
      end
      for (int k = 0; k < 150; k++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r < 7)
            a = BASE + 32'(pool[$urandom_range(0, 15)] * 4) + 32'($urandom_range(0, 3));
         else if (r < 9)
            a = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 32'h00FF_FFFF));
         else
            a = $urandom & 32'h1FFF_FFFF;
         if ($urandom_range(0, 1) == 0) begin
            logic [31:0] d;
            logic [3:0]  s;
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            axi_write(a, d, s, bs, wt);
            chk($sformatf("rnd%0d_bresp@%h", k, a), {30'h0, bs}, {30'h0, mdl_resp(a)});
         end else begin
            axi_read(a, rd, rs);
            chk($sformatf("rnd%0d_rdata@%h", k, a), rd, mdl_rdata(a));
            chk($sformatf("rnd%0d_rresp@%h", k, a), {30'h0, rs}, {30'h0, mdl_resp(a)});
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
